// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART frame transmit path: scheduler states and framing constants.
package uart_tx_pkg;

   localparam int unsigned FRAME_BYTES = 5160;
   localparam logic [7:0]  SYNC0       = 8'hAA;
   localparam logic [7:0]  SYNC1       = 8'h55;

   typedef enum logic [3:0] {
      StIdle,
      StHdr0,
      StHdr1,
      StLenHi,
      StLenLo,
      StPayRd,
      StPayCap,
      StPayPush,
      StCksum,
      StDone
   } tx_sched_state_t;

endpackage

// File: rtl/uart_frame_tx_sched.sv
// Streams one framed packet (sync, length, RAM payload, XOR checksum) into the UART TX FIFO
// per frame tick, with one queued request and a saturating drop counter.
module uart_frame_tx_sched #(
   parameter int unsigned FRAME_BYTES = uart_tx_pkg::FRAME_BYTES,
   parameter int unsigned ADDR_W      = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1,
   parameter logic [7:0]  SYNC0       = uart_tx_pkg::SYNC0,
   parameter logic [7:0]  SYNC1       = uart_tx_pkg::SYNC1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_tick,
   output logic              ram_re,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [7:0]        ram_rdata,
   input  logic              fifo_full,
   output logic              fifo_push,
   output logic [7:0]        fifo_data,
   output logic              busy,
   output logic              frame_done,
   output logic [7:0]        drop_cnt
);
   import uart_tx_pkg::*;

   localparam logic [15:0]       LEN      = 16'(FRAME_BYTES);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_BYTES - 1);

   tx_sched_state_t   state_q;
   logic              pending_q;
   logic [7:0]        cksum_q;
   logic [7:0]        hold_q;
   logic [ADDR_W-1:0] idx_q;
   logic [7:0]        drop_q;
   logic              push_state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         pending_q <= 1'b0;
         cksum_q   <= 8'h00;
         hold_q    <= 8'h00;
         idx_q     <= '0;
         drop_q    <= 8'h00;
      end else begin
         // DONE counts as busy, so a tick there queues rather than starting directly.
         if (frame_tick && state_q != StIdle) begin
            if (!pending_q) begin
               pending_q <= 1'b1;
            end else if (drop_q != 8'hFF) begin
               drop_q <= drop_q + 8'd1;
            end
         end

         unique case (state_q)
            StIdle: begin
               if (frame_tick || pending_q) begin
                  state_q <= StHdr0;
                  cksum_q <= 8'h00;
                  idx_q   <= '0;
                  if (pending_q && !frame_tick) pending_q <= 1'b0;
               end
            end
            StHdr0:  if (!fifo_full) state_q <= StHdr1;
            StHdr1:  if (!fifo_full) state_q <= StLenHi;
            StLenHi: if (!fifo_full) state_q <= StLenLo;
            StLenLo: if (!fifo_full) state_q <= StPayRd;
            StPayRd: state_q <= StPayCap;
            StPayCap: begin
               hold_q  <= ram_rdata;
               state_q <= StPayPush;
            end
            StPayPush: begin
               if (!fifo_full) begin
                  cksum_q <= cksum_q ^ hold_q;
                  if (idx_q == LAST_IDX) begin
                     idx_q   <= '0;
                     state_q <= StCksum;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                     state_q <= StPayRd;
                  end
               end
            end
            StCksum: if (!fifo_full) state_q <= StDone;
            StDone: begin
               cksum_q <= 8'h00;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Push must react to fifo_full in the same cycle, so it is decoded rather than registered.
   always_comb begin
      push_state = 1'b0;
      fifo_data  = 8'h00;
      unique case (state_q)
         StHdr0:    begin push_state = 1'b1; fifo_data = SYNC0;      end
         StHdr1:    begin push_state = 1'b1; fifo_data = SYNC1;      end
         StLenHi:   begin push_state = 1'b1; fifo_data = LEN[15:8];  end
         StLenLo:   begin push_state = 1'b1; fifo_data = LEN[7:0];   end
         StPayPush: begin push_state = 1'b1; fifo_data = hold_q;     end
         StCksum:   begin push_state = 1'b1; fifo_data = cksum_q;    end
         default:   ;
      endcase
   end

   assign fifo_push  = push_state && !fifo_full;
   assign ram_re     = (state_q == StPayRd);
   assign ram_addr   = ram_re ? idx_q : '0;
   assign busy       = (state_q != StIdle) && (state_q != StDone);
   assign frame_done = (state_q == StDone);
   assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_uart_frame_tx_sched.sv
// Scoreboard bench: a 4-byte-frame instance for timing/backpressure/reset cases and a
// default-size instance for the long random-backpressure and drop-saturation case.
module tb_uart_frame_tx_sched;

   localparam int unsigned SMALL_N  = 4;
   localparam int unsigned SMALL_AW = 2;
   localparam int unsigned BIG_N    = uart_tx_pkg::FRAME_BYTES;
   localparam int unsigned BIG_AW   = $clog2(BIG_N);

   logic clk;
   logic reset;

   logic                tick_s, re_s, full_s, push_s, busy_s, frame_done_s;
   logic [SMALL_AW-1:0] addr_s;
   logic [7:0]          rdata_s, data_s, drop_s;
   logic [7:0]          mem_s [SMALL_N];

   logic                tick_b, re_b, full_b, push_b, busy_b, frame_done_b;
   logic [BIG_AW-1:0]   addr_b;
   logic [7:0]          rdata_b, data_b, drop_b;
   logic [7:0]          mem_b [BIG_N];

   logic [7:0] exp_s [$];
   logic [7:0] exp_b [$];
   int n_checks = 0;
   int n_errors = 0;
   int done_cnt_s = 0, push_cnt_s = 0, re_cnt_s = 0, exp_addr_s = 0;
   int done_cnt_b = 0, exp_addr_b = 0;
   bit rand_full_b = 1'b0;

   uart_frame_tx_sched #(.FRAME_BYTES(SMALL_N)) u_small (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (tick_s),
      .ram_re     (re_s),
      .ram_addr   (addr_s),
      .ram_rdata  (rdata_s),
      .fifo_full  (full_s),
      .fifo_push  (push_s),
      .fifo_data  (data_s),
      .busy       (busy_s),
      .frame_done (frame_done_s),
      .drop_cnt   (drop_s)
   );

   uart_frame_tx_sched u_big (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (tick_b),
      .ram_re     (re_b),
      .ram_addr   (addr_b),
      .ram_rdata  (rdata_b),
      .fifo_full  (full_b),
      .fifo_push  (push_b),
      .fifo_data  (data_b),
      .busy       (busy_b),
      .frame_done (frame_done_b),
      .drop_cnt   (drop_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (re_s) rdata_s <= mem_s[addr_s];
      if (re_b) rdata_b <= mem_b[addr_b];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitors sample on the falling edge, half a cycle away from the push edge.
   always @(negedge clk) begin
      logic [7:0] e;
      if (!reset) begin
         exp_addr_s = 0;
      end else begin
         if (push_s) begin
            push_cnt_s++;
            check("s_push_while_full", full_s, 0);
            if (exp_s.size() == 0) check("s_extra_push", 32'(exp_s.size()), 1);
            else begin
               e = exp_s.pop_front();
               check("s_byte", data_s, e);
            end
         end
         if (re_s) begin
            re_cnt_s++;
            check("s_ram_addr", addr_s, exp_addr_s);
            exp_addr_s = (exp_addr_s + 1) % SMALL_N;
         end
         if (frame_done_s) done_cnt_s++;
      end
   end

   always @(negedge clk) begin
      logic [7:0] e;
      if (!reset) begin
         exp_addr_b = 0;
      end else begin
         if (push_b) begin
            check("b_push_while_full", full_b, 0);
            if (exp_b.size() == 0) check("b_extra_push", 32'(exp_b.size()), 1);
            else begin
               e = exp_b.pop_front();
               check("b_byte", data_b, e);
            end
         end
         if (re_b) begin
            check("b_ram_addr", addr_b, exp_addr_b);
            exp_addr_b = (exp_addr_b + 1) % BIG_N;
         end
         if (frame_done_b) done_cnt_b++;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         full_b = rand_full_b && ($urandom_range(0, 3) == 0);
      end
   end

   task automatic push_pkt_s();
      logic [7:0] x;
      logic [15:0] len;
      x = 8'h00;
      len = 16'(SMALL_N);
      exp_s.push_back(8'hAA);
      exp_s.push_back(8'h55);
      exp_s.push_back(len[15:8]);
      exp_s.push_back(len[7:0]);
      for (int i = 0; i < SMALL_N; i++) begin
         exp_s.push_back(mem_s[i]);
         x = x ^ mem_s[i];
      end
      exp_s.push_back(x);
   endtask

   task automatic push_pkt_b();
      logic [7:0] x;
      x = 8'h00;
      exp_b.push_back(8'hAA);
      exp_b.push_back(8'h55);
      exp_b.push_back(8'h14);
      exp_b.push_back(8'h28);
      for (int i = 0; i < BIG_N; i++) begin
         exp_b.push_back(mem_b[i]);
         x = x ^ mem_b[i];
      end
      exp_b.push_back(x);
   endtask

   task automatic pulse_s();
      @(posedge clk);
      #1 tick_s = 1'b1;
      @(posedge clk);
      #1 tick_s = 1'b0;
   endtask

   task automatic wait_done(input bit big, input int target, input int budget,
                            output int cycles);
      cycles = 0;
      while (cycles < budget && (big ? done_cnt_b : done_cnt_s) < target) begin
         @(negedge clk);
         #1;
         cycles++;
      end
      check(big ? "b_done_wait" : "s_done_wait", big ? done_cnt_b : done_cnt_s, target);
   endtask

   initial begin
      int n, d0, r0, p0;
      reset  = 1'b0;
      tick_s = 1'b0;
      tick_b = 1'b0;
      full_s = 1'b0;
      mem_s[0] = 8'h01; mem_s[1] = 8'h02; mem_s[2] = 8'h04; mem_s[3] = 8'h08;
      for (int i = 0; i < BIG_N; i++) mem_b[i] = 8'($urandom);

      repeat (3) @(posedge clk);
      #1;
      check("rst_push", push_s, 0);
      check("rst_re", re_s, 0);
      check("rst_busy", busy_s, 0);
      check("rst_done", frame_done_s, 0);
      check("rst_drop", drop_s, 0);
      check("rst_data", data_s, 0);
      reset = 1'b1;

      // Single frame, no backpressure.
      push_pkt_s();
      d0 = done_cnt_s;
      r0 = re_cnt_s;
      pulse_s();
      wait_done(1'b0, d0 + 1, 100, n);
      check("t1_done_latency", n, 18);
      check("t1_ram_re_count", re_cnt_s - r0, 4);
      check("t1_drained", exp_s.size(), 0);
      check("t1_busy_after", busy_s, 0);

      // Backpressure on LEN_LO (cycles 4..8) and payload byte 1 (cycles 15..19).
      push_pkt_s();
      d0 = done_cnt_s;
      pulse_s();
      repeat (3) @(posedge clk);
      #1 full_s = 1'b1;
      repeat (5) @(posedge clk);
      #1 full_s = 1'b0;
      repeat (6) @(posedge clk);
      #1 full_s = 1'b1;
      repeat (5) @(posedge clk);
      #1 full_s = 1'b0;
      wait_done(1'b0, d0 + 1, 100, n);
      check("t2_drained", exp_s.size(), 0);

      // Three ticks during one packet: one queued, two dropped.
      push_pkt_s();
      push_pkt_s();
      d0 = done_cnt_s;
      pulse_s();
      for (int k = 0; k < 3; k++) begin
         repeat (2) @(posedge clk);
         pulse_s();
      end
      wait_done(1'b0, d0 + 1, 100, n);
      wait_done(1'b0, d0 + 2, 100, n);
      check("t3_back_to_back_gap", n, 19);
      check("t3_drop_cnt", drop_s, 2);
      check("t3_drained", exp_s.size(), 0);

      // Reset during PAY_PUSH of payload byte 2 (cycle 13).
      push_pkt_s();
      pulse_s();
      repeat (13) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("t5_push", push_s, 0);
      check("t5_data", data_s, 0);
      check("t5_re", re_s, 0);
      check("t5_addr", addr_s, 0);
      check("t5_busy", busy_s, 0);
      check("t5_done", frame_done_s, 0);
      check("t5_drop", drop_s, 0);
      exp_s.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      d0 = done_cnt_s;
      p0 = push_cnt_s;
      repeat (25) @(negedge clk);
      #1;
      check("t5_no_push_after", push_cnt_s - p0, 0);
      check("t5_no_done_after", done_cnt_s - d0, 0);
      push_pkt_s();
      pulse_s();
      wait_done(1'b0, d0 + 1, 100, n);
      check("t5_restart_latency", n, 18);
      check("t5_drained", exp_s.size(), 0);

      // Default size, random backpressure, tick held 301 cycles: 1 start, 1 queued, 299 drops.
      rand_full_b = 1'b1;
      push_pkt_b();
      push_pkt_b();
      d0 = done_cnt_b;
      @(posedge clk);
      #1 tick_b = 1'b1;
      repeat (301) @(posedge clk);
      #1 tick_b = 1'b0;
      check("t6_drop_saturated", drop_b, 255);
      check("t6_busy", busy_b, 1);
      wait_done(1'b1, d0 + 2, 70000, n);
      check("t6_drained", exp_b.size(), 0);
      check("t6_drop_final", drop_b, 255);
      rand_full_b = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
